fx_bus_ctl: RTL

FX_BUS_CTL -- requirements
Module: fx_bus_ctl

---
 rtl/fx_bus_pkg.sv | 26 ++
 rtl/fx_rd_sel.sv | 40 ++++
 rtl/fx_bus_ctl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fx_bus_pkg.sv
// fx bus controller shared types and defaults.
// Error reporting for unmapped slaves is enabled with FX_BUS_ERR_EN.
package fx_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_DONE
  } fx_state_e;

  localparam int FX_NSLV    = 25;
  localparam int FX_AW      = 22;
  localparam int FX_DW      = 8;
  localparam int FX_SEL_LSB = 16;
  localparam int FX_RD_LAT  = 2;
  localparam int FX_CNT_W   = 4;

  function automatic logic fx_unmapped(
    input int idx,
    input int nslv
  );
    return idx >= nslv;
  endfunction

endpackage

// File: rtl/fx_rd_sel.sv
// Registered read-data mux: picks one slave slice of the
// concatenated bus, zero for any index past the last slave.
module fx_rd_sel
  import fx_bus_pkg::*;
#(
  parameter int NSLV = FX_NSLV,
  parameter int DW   = FX_DW,
  parameter int IW   = FX_AW - FX_SEL_LSB
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sample_i,
  input  logic [IW-1:0]    idx_i,
  input  logic [NSLV*DW-1:0] fx_q_all_i,
  output logic [DW-1:0]    q_o
);

  logic [DW-1:0] slice_d;
  logic [DW-1:0] q_q;

  always_comb begin
    slice_d = '0;
    for (int k = 0; k < NSLV; k++) begin
      if (int'(idx_i) == k) begin
        slice_d = fx_q_all_i[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (sample_i) begin
      q_q <= slice_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fx_bus_ctl.sv
// fx bus master-to-slave controller: one write or read in flight.
// FX_BUS_ERR_EN suppresses strobes to unmapped slaves and flags ufx_err.
module fx_bus_ctl
  import fx_bus_pkg::*;
#(
  parameter int NSLV    = FX_NSLV,
  parameter int AW      = FX_AW,
  parameter int DW      = FX_DW,
  parameter int SEL_LSB = FX_SEL_LSB,
  parameter int RD_LAT  = FX_RD_LAT
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               ufx_wr,
  input  logic [AW-1:0]      ufx_waddr,
  input  logic [DW-1:0]      ufx_data,
  input  logic               ufx_rd,
  input  logic [AW-1:0]      ufx_raddr,
  output logic [DW-1:0]      ufx_q,
  output logic               ufx_ack,
  output logic               ufx_busy,
  output logic               ufx_err,
  output logic               fx_wr,
  output logic [AW-1:0]      fx_waddr,
  output logic [DW-1:0]      fx_data,
  output logic               fx_rd,
  output logic [AW-1:0]      fx_raddr,
  input  logic [NSLV*DW-1:0] fx_q_all
);

  localparam int IW = AW - SEL_LSB;
  localparam logic [FX_CNT_W-1:0] LAT = FX_CNT_W'(RD_LAT);

`ifdef FX_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [1:0]          rs_q;
  logic                rst_int;
  fx_state_e           state_q;
  logic [FX_CNT_W-1:0] cnt_q;
  logic [FX_CNT_W-1:0] cnt_d;
  logic                fx_wr_q;
  logic                fx_rd_q;
  logic                ack_q;
  logic                err_q;
  logic                err_pend_q;
  logic [AW-1:0]       waddr_q;
  logic [DW-1:0]       data_q;
  logic [AW-1:0]       raddr_q;
  logic [IW-1:0]       widx;
  logic [IW-1:0]       ridx;
  logic [IW-1:0]       cidx;
  logic                w_bad;
  logic                r_bad;
  logic                sample;

  // Assert immediately, release two clk_sys edges after rst falls.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rs_q <= 2'b11;
    end else begin
      rs_q <= {rs_q[0], 1'b0};
    end
  end

  assign rst_int = rs_q[1];

  assign widx   = ufx_waddr[AW-1:SEL_LSB];
  assign ridx   = ufx_raddr[AW-1:SEL_LSB];
  assign cidx   = raddr_q[AW-1:SEL_LSB];
  assign w_bad  = ERR_EN && fx_unmapped(int'(widx), NSLV);
  assign r_bad  = ERR_EN && fx_unmapped(int'(ridx), NSLV);
  assign sample = (state_q == ST_RD) && (cnt_q == LAT);

  always_comb begin
    cnt_d = '0;
    if (state_q == ST_RD) begin
      cnt_d = cnt_q + FX_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge rst_int) begin
    if (rst_int) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fx_wr_q    <= 1'b0;
      fx_rd_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      waddr_q    <= '0;
      data_q     <= '0;
      raddr_q    <= '0;
    end else begin
      fx_wr_q <= 1'b0;
      fx_rd_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= cnt_d;
      unique case (state_q)
        ST_IDLE: begin
          if (ufx_wr) begin
            waddr_q <= ufx_waddr;
            data_q  <= ufx_data;
            fx_wr_q <= !w_bad;
            ack_q   <= 1'b1;
            err_q   <= w_bad;
            state_q <= ST_WR;
          end else if (ufx_rd) begin
            raddr_q    <= ufx_raddr;
            fx_rd_q    <= !r_bad;
            err_pend_q <= r_bad;
            state_q    <= ST_RD;
          end
        end
        ST_WR: begin
          state_q <= ST_IDLE;
        end
        ST_RD: begin
          if (cnt_q == LAT) begin
            ack_q   <= 1'b1;
            err_q   <= err_pend_q;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  fx_rd_sel #(
    .NSLV (NSLV),
    .DW   (DW),
    .IW   (IW)
  ) u_rd_sel (
    .clk_i      (clk_sys),
    .rst_i      (rst_int),
    .sample_i   (sample),
    .idx_i      (cidx),
    .fx_q_all_i (fx_q_all),
    .q_o        (ufx_q)
  );

  assign ufx_ack  = ack_q;
  assign ufx_err  = err_q;
  assign ufx_busy = (state_q != ST_IDLE);
  assign fx_wr    = fx_wr_q;
  assign fx_rd    = fx_rd_q;
  assign fx_waddr = waddr_q;
  assign fx_data  = data_q;
  assign fx_raddr = raddr_q;

endmodule
